// File: rtl/digit_stream_ctrl_pkg.sv
// Shared definitions for the BCD-to-ASCII digit streamer: FSM encoding,
// ASCII constants and the nibble-to-character conversion.
package digit_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CR    = 3'd3,
    ST_LF    = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_BAD  = 8'h3F;

  // Non-BCD nibbles are shown as '?' so a corrupt result is still visible.
  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    if (d <= 4'd9) return ASCII_ZERO + {4'h0, d};
    else           return ASCII_BAD;
  endfunction

endpackage

// File: rtl/digit_extractor.sv
// Selects one BCD nibble out of the 8-digit snapshot; digit 0 sits in bits [3:0].
module digit_extractor (
  input  logic [31:0] snapshot,
  input  logic [2:0]  idx,
  output logic [3:0]  digit
);

  assign digit = snapshot[{idx, 2'b00} +: 4];

endmodule

// File: rtl/digit_stream_ctrl.sv
// Streams the snapshotted 8-digit BCD result to the UART TX byte interface,
// most significant digit first, with optional leading-zero blanking and CR/LF.
//
// state | meaning
// IDLE  | waiting for start; busy low
// FETCH | look up digit idx; skip it if it is a blanked leading zero
// SEND  | digit byte presented, waiting for tx_ready
// CR    | carriage return presented
// LF    | line feed presented; frame ends on its handshake
module digit_stream_ctrl
  import digit_stream_ctrl_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit SEND_CRLF     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] digits_a,
  input  logic [15:0] digits_b,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        lz_q, lz_d;
  logic [31:0] snap_q, snap_d;
  logic [7:0]  data_d;
  logic        valid_d, busy_d, done_d;
  logic [3:0]  digit;

  digit_extractor u_digit_extractor (
    .snapshot (snap_q),
    .idx      (idx_q),
    .digit    (digit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd7;
      lz_q     <= 1'b1;
      snap_q   <= 32'h0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lz_q     <= lz_d;
      snap_q   <= snap_d;
      tx_data  <= data_d;
      tx_valid <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lz_d    = lz_q;
    snap_d  = snap_q;
    data_d  = tx_data;
    valid_d = tx_valid;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = {digits_b, digits_a};
          idx_d   = 3'd7;
          lz_d    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Digit 0 is never blanked so an all-zero value still prints "0".
        if (BLANK_LEADING && lz_q && (digit == 4'd0) && (idx_q != 3'd0)) begin
          idx_d = idx_q - 3'd1;
        end else begin
          data_d  = to_ascii(digit);
          valid_d = 1'b1;
          lz_d    = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q != 3'd0) begin
            valid_d = 1'b0;
            idx_d   = idx_q - 3'd1;
            state_d = ST_FETCH;
          end else if (SEND_CRLF) begin
            data_d  = ASCII_CR;
            state_d = ST_CR;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_CR: begin
        if (tx_ready) begin
          data_d  = ASCII_LF;
          state_d = ST_LF;
        end
      end
      ST_LF: begin
        if (tx_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_digit_stream_ctrl.sv
// Self-checking bench: three parameter variants share stimulus; a frame-level
// model predicts bytes, gaps, busy and done, and directed literals pin the model.
module tb_digit_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [15:0] digits_a = 16'h0;
  logic [15:0] digits_b = 16'h0;

  logic [7:0] tx_data_w [3];
  logic       tx_valid_w [3];
  logic       busy_w [3];
  logic       done_w [3];

  always #5 clk = ~clk;

  digit_stream_ctrl #(.BLANK_LEADING(1'b1), .SEND_CRLF(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digits_a(digits_a), .digits_b(digits_b),
    .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]), .tx_ready(tx_ready),
    .busy(busy_w[0]), .done(done_w[0]));

  digit_stream_ctrl #(.BLANK_LEADING(1'b0), .SEND_CRLF(1'b1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .start(start), .digits_a(digits_a), .digits_b(digits_b),
    .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]), .tx_ready(tx_ready),
    .busy(busy_w[1]), .done(done_w[1]));

  digit_stream_ctrl #(.BLANK_LEADING(1'b1), .SEND_CRLF(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .start(start), .digits_a(digits_a), .digits_b(digits_b),
    .tx_data(tx_data_w[2]), .tx_valid(tx_valid_w[2]), .tx_ready(tx_ready),
    .busy(busy_w[2]), .done(done_w[2]));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [dut%0d] @%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  function automatic bit blank_of(input int k);
    return k != 1;
  endfunction

  function automatic bit crlf_of(input int k);
    return k != 2;
  endfunction

  // Model: expected byte list per frame and, per byte, how many cycles
  // tx_valid must stay low before it appears.
  logic [7:0] exp_b [3][10];
  int         exp_g [3][10];
  int         exp_len [3];
  int         exp_ptr [3];
  int         gap [3];
  bit         m_busy [3];
  bit         m_done [3];
  bit         prev_stall [3];
  logic [7:0] prev_data [3];

  logic [7:0] cap [3][10];
  int         cap_len [3];
  int         done_cnt [3];
  int         nv_cnt [3];

  task automatic load_frame(input int k, input logic [31:0] snap);
    int n = 0;
    int nblank = 0;
    bit lead = blank_of(k);
    logic [3:0] d;
    for (int i = 7; i >= 0; i--) begin
      d = snap[i*4 +: 4];
      if (lead && d == 4'd0 && i != 0) begin
        nblank++;
      end else begin
        lead = 1'b0;
        exp_b[k][n] = (d <= 4'd9) ? 8'h30 + {4'h0, d} : 8'h3F;
        exp_g[k][n] = (n == 0) ? 1 + nblank : 1;
        n++;
      end
    end
    if (crlf_of(k)) begin
      exp_b[k][n] = 8'h0D; exp_g[k][n] = 0; n++;
      exp_b[k][n] = 8'h0A; exp_g[k][n] = 0; n++;
    end
    exp_len[k]  = n;
    exp_ptr[k]  = 0;
    gap[k]      = exp_g[k][0];
    cap_len[k]  = 0;
    done_cnt[k] = 0;
    nv_cnt[k]   = 0;
    m_busy[k]   = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_done[k] = 0; prev_stall[k] = 0; prev_data[k] = 8'h0;
      gap[k] = 0; cap_len[k] = 0; done_cnt[k] = 0; nv_cnt[k] = 0;
      exp_len[k] = 0; exp_ptr[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          m_busy[k] = 0; m_done[k] = 0; prev_stall[k] = 0;
          check("reset_valid", k, tx_valid_w[k], 0);
          check("reset_busy", k, busy_w[k], 0);
          check("reset_done", k, done_w[k], 0);
          check("reset_data", k, tx_data_w[k], 8'h00);
        end else begin
          bit cur_valid;
          cur_valid = m_busy[k] && gap[k] == 0;
          check("busy", k, busy_w[k], m_busy[k]);
          check("done", k, done_w[k], m_done[k]);
          check("valid", k, tx_valid_w[k], cur_valid);
          if (prev_stall[k]) check("hold_data", k, tx_data_w[k], prev_data[k]);
          if (done_w[k]) done_cnt[k]++;
          if (m_busy[k] && cap_len[k] == 0 && !tx_valid_w[k]) nv_cnt[k]++;
          m_done[k] = 0;
          prev_stall[k] = cur_valid && !tx_ready;
          prev_data[k]  = tx_data_w[k];
          if (m_busy[k]) begin
            if (gap[k] > 0) begin
              gap[k]--;
            end else if (tx_ready) begin
              check("byte", k, tx_data_w[k], exp_b[k][exp_ptr[k]]);
              cap[k][cap_len[k]] = tx_data_w[k];
              cap_len[k]++;
              exp_ptr[k]++;
              if (exp_ptr[k] == exp_len[k]) begin
                m_busy[k] = 0;
                m_done[k] = 1;
              end else begin
                gap[k] = exp_g[k][exp_ptr[k]];
              end
            end
          end else if (start) begin
            load_frame(k, {digits_b, digits_a});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && n < 400) begin
      tick();
      n++;
    end
    check("idle_timeout", 0, {29'h0, busy_w[2], busy_w[1], busy_w[0]}, 0);
    tick();
  endtask

  task automatic check_frame(input string name, input int k, input string s);
    check({name, "_len"}, k, cap_len[k], s.len());
    for (int i = 0; i < s.len() && i < cap_len[k]; i++)
      check({name, "_char"}, k, cap[k][i], {24'h0, s[i]});
  endtask

  initial begin
    int stall_cnt;
    int n;
    repeat (3) @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();

    // Full 8-digit frame, ready always high.
    tx_ready = 1'b1;
    digits_b = 16'h8765; digits_a = 16'h4321;
    pulse_start();
    wait_idle();
    check_frame("t1", 0, "87654321\r\n");
    check_frame("t1", 1, "87654321\r\n");
    check_frame("t1", 2, "87654321");
    for (int k = 0; k < 3; k++) check("t1_done_cnt", k, done_cnt[k], 1);
    check("t1_first_latency", 0, nv_cnt[0], 1);

    // Leading zeros: five blanked digits, each one extra FETCH cycle.
    digits_b = 16'h0000; digits_a = 16'h0345;
    pulse_start();
    wait_idle();
    check_frame("t2", 0, "345\r\n");
    check_frame("t2", 1, "00000345\r\n");
    check_frame("t2", 2, "345");
    check("t2_blank_cycles", 0, nv_cnt[0] - 1, 5);
    check("t2_noblank_latency", 1, nv_cnt[1], 1);

    // All zero.
    digits_b = 16'h0000; digits_a = 16'h0000;
    pulse_start();
    wait_idle();
    check_frame("t3", 0, "0\r\n");
    check_frame("t3", 1, "00000000\r\n");
    check_frame("t3", 2, "0");
    check("t3_done_cnt", 2, done_cnt[2], 1);

    // Random ready, 3-cycle stall on the second byte, input changed mid-frame.
    tx_ready = 1'b0;
    digits_b = 16'h1234; digits_a = 16'h5678;
    pulse_start();
    stall_cnt = 0;
    n = 0;
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && n < 400) begin
      if (n == 4) digits_a = 16'h9999;
      if (cap_len[0] == 1 && tx_valid_w[0] && stall_cnt < 3) begin
        tx_ready = 1'b0;
        stall_cnt++;
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    tx_ready = 1'b1;
    wait_idle();
    check("t4_stall_seen", 0, stall_cnt, 3);
    check_frame("t4", 0, "12345678\r\n");
    check_frame("t4", 2, "12345678");
    check("t4_done_cnt", 0, done_cnt[0], 1);

    // Non-BCD nibble ends blanking; the trailing zero is sent.
    digits_b = 16'h0000; digits_a = 16'h00A0;
    pulse_start();
    wait_idle();
    check_frame("t5", 0, "?0\r\n");
    check_frame("t5", 1, "000000?0\r\n");
    check_frame("t5", 2, "?0");

    // Reset while CR is on the bus.
    digits_b = 16'h8765; digits_a = 16'h4321;
    pulse_start();
    n = 0;
    while (!(tx_valid_w[0] && tx_data_w[0] == 8'h0D) && n < 100) begin
      tick();
      n++;
    end
    check("t6_cr_reached", 0, tx_data_w[0], 8'h0D);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t6_async_valid", k, tx_valid_w[k], 0);
      check("t6_async_busy", k, busy_w[k], 0);
      check("t6_async_done", k, done_w[k], 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) check("t6_no_done", k, done_cnt[k], 0);

    // Fresh frame after reset; a second start while busy is ignored.
    digits_b = 16'h0042; digits_a = 16'h0007;
    pulse_start();
    tick();
    digits_b = 16'h9999; digits_a = 16'h9999;
    pulse_start();
    wait_idle();
    check_frame("t7", 0, "420007\r\n");
    check_frame("t7", 1, "00420007\r\n");
    check_frame("t7", 2, "420007");
    for (int k = 0; k < 3; k++) check("t7_done_cnt", k, done_cnt[k], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
